miss_req_issuer: RTL and testbench
==================================

// Module: miss_req_issuer
// PURPOSE
//  Upstream of the outstanding-request CAM. Accepts one cache-miss request at a time and holds it while the
//  CAM shows the same line in flight or has no free entry. Then allocates a CAM entry (tag = entry index)
//  and issues the request on the memory bus. Frees the entry when a bus response returns its tag.
// PARAMETERS
//  ADDR_WIDTH  58  line address width; equals CAM_WIDTH of the CAM
//  TAG_WIDTH   2   tag / CAM index width; equals LOG_DEPTH of the CAM
// PORTS
//  clk             in   1           clock; all state on posedge
//  reset           in   1           asynchronous, active-low (0 = reset)
//  req_valid       in   1           miss request valid
//  req_ready       out  1           request accepted when req_valid & req_ready
//  req_addr        in   ADDR_WIDTH  miss line address
//  req_write       in   1           1 = write-back, 0 = fill read
//  cam_data        out  ADDR_WIDTH  lookup key to CAM
//  cam_exists      in   1           CAM hit on cam_data
//  cam_full        in   1           CAM has no free entry
//  cam_push        out  1           allocate CAM entry
//  cam_push_index  in   TAG_WIDTH   index the CAM will fill on push
//  cam_data_in     out  ADDR_WIDTH+1  {req_write, addr} written on push
//  cam_pop         out  1           release CAM entry
//  cam_pop_index   out  TAG_WIDTH   entry to release
//  bus_req_valid   out  1           bus request valid
//  bus_req_ack     in   1           bus accepted request this cycle
//  bus_req_addr    out  ADDR_WIDTH  bus request address
//  bus_req_write   out  1           bus request type
//  bus_req_tag     out  TAG_WIDTH   tag (= CAM index) returned with response
//  bus_resp_valid  in   1           response for bus_resp_tag this cycle
//  bus_resp_tag    in   TAG_WIDTH   tag of completing request
// BEHAVIOUR
//  FSM states: IDLE, LOOKUP, ISSUE. Reset value is IDLE.
//   - Reset clears the held addr/write/tag registers to 0.
//   - During reset, every output is 0 except req_ready, which is 1 once reset deasserts (IDLE).
//  IDLE: req_ready=1. On req_valid, latch req_addr and req_write, then go to LOOKUP.
//  LOOKUP: req_ready=0. cam_data = held addr, driven in every state (0 after reset).
//   - Allocate condition: !cam_exists & !cam_full & !bus_resp_valid.
//   - When the condition holds: cam_push=1, latch tag <= cam_push_index, go to ISSUE.
//   - Otherwise stay in LOOKUP. Re-evaluate every cycle; no timeout.
//   - The CAM drops a pop that coincides with a push, so a push never shares a cycle with a pop. The pop wins.
//  ISSUE: bus_req_valid=1, with addr/write/tag held stable until ack.
//   - On bus_req_ack, go to IDLE. With an ack in the first ISSUE cycle, bus_req_valid is high exactly 1 cycle.
//  Response path is independent of FSM state.
//   - cam_pop = bus_resp_valid, cam_pop_index = bus_resp_tag. Both are combinational, zero latency.
//   - A response with a tag that is not outstanding is a bus protocol error; flag it with an assertion only.
//  cam_data_in = {write, addr}, driven from the held registers.
//  Latency: accept at cycle 0, push at cycle 1 (best case), bus_req_valid at cycle 2, next accept no earlier
//   than cycle 3. Peak rate is 1 request per 3 cycles.
//  Boundaries:
//   - Duplicate line in flight: stall in LOOKUP until the matching pop has taken effect (cam_exists low).
//   - CAM full: stall. A pop frees an entry; the push happens the cycle after the pop at the earliest.
//   - bus_resp_valid held high continuously: LOOKUP starves. This is allowed; the bus must leave gaps.
//   - Reset asserted mid-operation: return to IDLE immediately; any partially issued request is lost.
//     The CAM must be reset in the same window.
// CONFIGURATION
//  MISS_ISSUER_STATS_EN defined:
//   - Adds outputs stat_issued[31:0] and stat_stall_cycles[31:0].
//   - stat_issued increments on each bus_req_valid & bus_req_ack.
//   - stat_stall_cycles increments on each LOOKUP cycle without a push.
//   - Both counters reset to 0 and wrap modulo 2^32.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Empty CAM: req addr=0x40, write=0, ack on first ISSUE cycle.
//    -> push at cycle 1 with index 0; bus_req_valid at cycle 2 with addr 0x40, tag 0; req_ready high at cycle 3.
//  2 addr 0x80 outstanding at tag 1, new req 0x80 -> stall in LOOKUP. Then resp tag 1 -> cam_pop in the same
//    cycle; push at the first cycle after cam_exists drops; new tag = cam_push_index.
//  3 CAM full (4 entries), req 0x100 -> no push and req_ready=0. resp tag 2 -> push next cycle, bus_req_tag=2.
//  4 bus_resp_valid in the same cycle the push condition is otherwise met -> cam_pop=1, cam_push=0;
//    push occurs one cycle later.
//  5 Assert reset in ISSUE with ack withheld -> bus_req_valid drops asynchronously; after release req_ready=1.
//  6 With MISS_ISSUER_STATS_EN: 3 requests plus the 2-cycle dup stall of scenario 2
//    -> stat_issued=3, stat_stall_cycles=2.

Source files
------------

// File: rtl/miss_req_issuer.sv
// Miss request issuer: holds one miss until the outstanding-request CAM can take it, then issues it on the bus.
// Optional MISS_ISSUER_STATS_EN adds issued / stall-cycle counters.
module miss_req_issuer #(
   parameter int unsigned ADDR_WIDTH = 58,
   parameter int unsigned TAG_WIDTH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   output logic [ADDR_WIDTH-1:0] cam_data,
   input  logic                  cam_exists,
   input  logic                  cam_full,
   output logic                  cam_push,
   input  logic [TAG_WIDTH-1:0]  cam_push_index,
   output logic [ADDR_WIDTH:0]   cam_data_in,
   output logic                  cam_pop,
   output logic [TAG_WIDTH-1:0]  cam_pop_index,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ack,
   output logic [ADDR_WIDTH-1:0] bus_req_addr,
   output logic                  bus_req_write,
   output logic [TAG_WIDTH-1:0]  bus_req_tag,
   input  logic                  bus_resp_valid,
   input  logic [TAG_WIDTH-1:0]  bus_resp_tag
`ifdef MISS_ISSUER_STATS_EN
   ,
   output logic [31:0]           stat_issued,
   output logic [31:0]           stat_stall_cycles
`endif
);

   localparam int unsigned Entries = 2 ** TAG_WIDTH;

   typedef enum logic [1:0] {StIdle, StLookup, StIssue} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic                    req_ready_q, req_ready_d;
   logic                    bus_req_valid_q, bus_req_valid_d;
   logic [Entries-1:0]      outstanding_q, outstanding_d;
   logic                    alloc;

   // A response pop always wins over a push in the same cycle.
   assign alloc = (state_q == StLookup) & ~cam_exists & ~cam_full & ~bus_resp_valid;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      write_d       = write_q;
      tag_d         = tag_q;
      outstanding_d = outstanding_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready_q) begin
               addr_d  = req_addr;
               write_d = req_write;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (alloc) begin
               tag_d   = cam_push_index;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (bus_req_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (bus_resp_valid) outstanding_d[bus_resp_tag] = 1'b0;
      if (alloc)          outstanding_d[cam_push_index] = 1'b1;
      req_ready_d     = (state_d == StIdle);
      bus_req_valid_d = (state_d == StIssue);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         write_q         <= 1'b0;
         tag_q           <= '0;
         req_ready_q     <= 1'b0;
         bus_req_valid_q <= 1'b0;
         outstanding_q   <= '0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         write_q         <= write_d;
         tag_q           <= tag_d;
         req_ready_q     <= req_ready_d;
         bus_req_valid_q <= bus_req_valid_d;
         outstanding_q   <= outstanding_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign cam_data      = addr_q;
   assign cam_push      = alloc;
   assign cam_data_in   = {write_q, addr_q};
   assign cam_pop       = bus_resp_valid;
   assign cam_pop_index = bus_resp_tag;
   assign bus_req_valid = bus_req_valid_q;
   assign bus_req_addr  = addr_q;
   assign bus_req_write = write_q;
   assign bus_req_tag   = tag_q;

   // A response must name a tag this block allocated and has not yet seen freed.
   unknown_resp_tag_a: assert property (@(posedge clk) disable iff (!reset)
      bus_resp_valid |-> outstanding_q[bus_resp_tag]);

`ifdef MISS_ISSUER_STATS_EN
   logic [31:0] stat_issued_q, stat_issued_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   always_comb begin
      stat_issued_d = stat_issued_q;
      stat_stall_d  = stat_stall_q;
      if (bus_req_valid_q && bus_req_ack)          stat_issued_d = stat_issued_q + 32'd1;
      if ((state_q == StLookup) && !alloc)         stat_stall_d  = stat_stall_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_issued_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         stat_issued_q <= stat_issued_d;
         stat_stall_q  <= stat_stall_d;
      end
   end

   assign stat_issued       = stat_issued_q;
   assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_miss_req_issuer.sv
// Bench for miss_req_issuer: behavioural 4-entry CAM, request table plus hand-written stall/reset sequences,
// scoreboard of expected bus requests.
module tb_miss_req_issuer;

   localparam int unsigned AW = 58;
   localparam int unsigned TW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready;
   logic [AW-1:0] req_addr;
   logic          req_write;
   logic [AW-1:0] cam_data;
   logic          cam_exists, cam_full, cam_push;
   logic [TW-1:0] cam_push_index;
   logic [AW:0]   cam_data_in;
   logic          cam_pop;
   logic [TW-1:0] cam_pop_index;
   logic          bus_req_valid, bus_req_ack;
   logic [AW-1:0] bus_req_addr;
   logic          bus_req_write;
   logic [TW-1:0] bus_req_tag;
   logic          bus_resp_valid;
   logic [TW-1:0] bus_resp_tag;
`ifdef MISS_ISSUER_STATS_EN
   logic [31:0]   stat_issued, stat_stall_cycles;
`endif

   miss_req_issuer #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_write(req_write),
      .cam_data(cam_data), .cam_exists(cam_exists), .cam_full(cam_full), .cam_push(cam_push),
      .cam_push_index(cam_push_index), .cam_data_in(cam_data_in), .cam_pop(cam_pop),
      .cam_pop_index(cam_pop_index), .bus_req_valid(bus_req_valid), .bus_req_ack(bus_req_ack),
      .bus_req_addr(bus_req_addr), .bus_req_write(bus_req_write), .bus_req_tag(bus_req_tag),
      .bus_resp_valid(bus_resp_valid), .bus_resp_tag(bus_resp_tag)
`ifdef MISS_ISSUER_STATS_EN
      , .stat_issued(stat_issued), .stat_stall_cycles(stat_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural CAM: lowest free index is offered for the next push; a pop alongside a push is dropped.
   logic [3:0]    cv_q;
   logic [AW-1:0] ca_q [4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cv_q <= '0;
      end else if (cam_push) begin
         cv_q[cam_push_index] <= 1'b1;
         ca_q[cam_push_index] <= cam_data_in[AW-1:0];
      end else if (cam_pop) begin
         cv_q[cam_pop_index] <= 1'b0;
      end
   end

   always_comb begin
      cam_exists     = 1'b0;
      cam_push_index = '0;
      for (int i = 3; i >= 0; i--) if (!cv_q[i]) cam_push_index = TW'(i);
      for (int i = 0; i < 4; i++) if (cv_q[i] && (ca_q[i] == cam_data)) cam_exists = 1'b1;
      cam_full = &cv_q;
   end

   typedef struct {
      logic [AW-1:0] addr;
      logic          write;
      logic [TW-1:0] tag;
   } exp_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic          write;
      int            ack_dly;
      logic [TW-1:0] tag;
      bit            free_after;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_issued = 0;
   int   exp_stall = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_cmp(input bit pop);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_underflow: got bus request with no expected entry");
         return;
      end
      e = sb[0];
      chk("bus_req_addr", 64'(bus_req_addr), 64'(e.addr));
      chk("bus_req_write", 64'(bus_req_write), 64'(e.write));
      chk("bus_req_tag", 64'(bus_req_tag), 64'(e.tag));
      if (pop) e = sb.pop_front();
   endtask

   // Cycle 0: present the request and expect acceptance.
   task automatic send(input logic [AW-1:0] a, input logic w, input logic [TW-1:0] tg);
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      #1;
      chk("req_ready_accept", 64'(req_ready), 64'd1);
      e.addr = a; e.write = w; e.tag = tg;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
   endtask

   // Called after the push cycle: bus_req_valid must appear in the next cycle and hold until ack.
   task automatic issue_phase(input int ack_dly);
      int n = 0;
      bit done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         bus_req_ack = bus_req_valid && (n == ack_dly);
         #1;
         if (bus_req_valid) begin
            if (n == 0) chk("issue_latency", 64'(c), 64'd0);
            if (n == ack_dly) begin
               sb_cmp(1'b1);
               exp_issued++;
               done = 1'b1;
            end else begin
               sb_cmp(1'b0);
            end
            n++;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got no bus_req_valid expected one within 40 cycles");
      end
      @(negedge clk);
      bus_req_ack = 1'b0;
      #1;
      chk("ready_after_ack", 64'(req_ready), 64'd1);
      chk("valid_after_ack", 64'(bus_req_valid), 64'd0);
   endtask

   task automatic do_req(input logic [AW-1:0] a, input logic w, input int ack_dly,
                         input logic [TW-1:0] tg);
      send(a, w, tg);
      @(negedge clk);
      #1;
      chk("push_c1", 64'(cam_push), 64'd1);
      chk("push_data_c1", 64'(cam_data_in), 64'({w, a}));
      chk("ready_c1", 64'(req_ready), 64'd0);
      issue_phase(ack_dly);
   endtask

   task automatic resp(input logic [TW-1:0] t);
      @(negedge clk);
      bus_resp_valid = 1'b1;
      bus_resp_tag   = t;
      #1;
      chk("cam_pop", 64'(cam_pop), 64'd1);
      chk("cam_pop_index", 64'(cam_pop_index), 64'(t));
      @(posedge clk);
      #1;
      bus_resp_valid = 1'b0;
      bus_resp_tag   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[4];
      tbl[0] = '{addr: 58'h40,       write: 1'b0, ack_dly: 0, tag: 2'd0, free_after: 1'b0};
      tbl[1] = '{addr: 58'h80,       write: 1'b1, ack_dly: 1, tag: 2'd1, free_after: 1'b0};
      tbl[2] = '{addr: {58{1'b1}},   write: 1'b1, ack_dly: 2, tag: 2'd2, free_after: 1'b1};
      tbl[3] = '{addr: 58'hABC,      write: 1'b0, ack_dly: 0, tag: 2'd2, free_after: 1'b0};

      reset = 1'b0;
      req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
      bus_req_ack = 1'b0; bus_resp_valid = 1'b0; bus_resp_tag = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_bus_valid", 64'(bus_req_valid), 64'd0);
      chk("rst_cam_push", 64'(cam_push), 64'd0);
      chk("rst_cam_data", 64'(cam_data), 64'd0);
      chk("rst_cam_data_in", 64'(cam_data_in), 64'd0);
      chk("rst_bus_tag", 64'(bus_req_tag), 64'd0);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("ready_after_reset", 64'(req_ready), 64'd1);

      for (int i = 0; i < 4; i++) begin
         do_req(tbl[i].addr, tbl[i].write, tbl[i].ack_dly, tbl[i].tag);
         if (tbl[i].free_after) resp(tbl[i].tag);
      end

      // Duplicate of in-flight 0x80 (tag 1): stall until its pop lands.
      send(58'h80, 1'b0, 2'd1);
      @(negedge clk); #1;
      chk("dup_no_push", 64'(cam_push), 64'd0);
      chk("dup_ready_low", 64'(req_ready), 64'd0);
      @(negedge clk);
      bus_resp_valid = 1'b1; bus_resp_tag = 2'd1;
      #1;
      chk("dup_pop", 64'(cam_pop), 64'd1);
      chk("dup_pop_index", 64'(cam_pop_index), 64'd1);
      chk("dup_no_push_on_pop", 64'(cam_push), 64'd0);
      @(negedge clk);
      bus_resp_valid = 1'b0; bus_resp_tag = '0;
      #1;
      chk("dup_push", 64'(cam_push), 64'd1);
      issue_phase(0);
      exp_stall += 2;

      // Fill the last entry, then a new miss must wait for a free slot.
      do_req(58'h200, 1'b1, 1, 2'd3);
      send(58'h100, 1'b0, 2'd2);
      @(negedge clk); #1;
      chk("full_no_push", 64'(cam_push), 64'd0);
      chk("full_ready_low", 64'(req_ready), 64'd0);
      @(negedge clk);
      bus_resp_valid = 1'b1; bus_resp_tag = 2'd2;
      #1;
      chk("full_pop", 64'(cam_pop), 64'd1);
      chk("full_no_push_on_pop", 64'(cam_push), 64'd0);
      @(negedge clk);
      bus_resp_valid = 1'b0; bus_resp_tag = '0;
      #1;
      chk("full_push", 64'(cam_push), 64'd1);
      issue_phase(0);
      exp_stall += 2;

      // Response collides with an otherwise-ready push.
      resp(2'd0);
      send(58'h300, 1'b1, 2'd0);
      @(negedge clk);
      bus_resp_valid = 1'b1; bus_resp_tag = 2'd3;
      #1;
      chk("coll_pop", 64'(cam_pop), 64'd1);
      chk("coll_no_push", 64'(cam_push), 64'd0);
      @(negedge clk);
      bus_resp_valid = 1'b0; bus_resp_tag = '0;
      #1;
      chk("coll_push", 64'(cam_push), 64'd1);
      issue_phase(1);
      exp_stall += 1;

`ifdef MISS_ISSUER_STATS_EN
      chk("stat_issued", 64'(stat_issued), 64'(exp_issued));
      chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'(exp_stall));
`endif

      // Reset while a request sits in ISSUE without ack.
      send(58'h500, 1'b0, 2'd3);
      @(negedge clk); #1;
      chk("rst5_push", 64'(cam_push), 64'd1);
      @(negedge clk); #1;
      chk("rst5_issue_valid", 64'(bus_req_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst5_valid_drop", 64'(bus_req_valid), 64'd0);
      chk("rst5_ready_low", 64'(req_ready), 64'd0);
      chk("rst5_addr_clear", 64'(bus_req_addr), 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rst5_ready_back", 64'(req_ready), 64'd1);
      chk("rst5_valid_low", 64'(bus_req_valid), 64'd0);
`ifdef MISS_ISSUER_STATS_EN
      chk("rst5_stat_issued", 64'(stat_issued), 64'd0);
      chk("rst5_stat_stall", 64'(stat_stall_cycles), 64'd0);
`endif

      do_req(58'h40, 1'b1, 0, 2'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
